// File: rtl/mips_pkg.sv
// Shared MIPS datapath definitions: ALU op codes, word width and HI/LO unit state.
package mips_pkg;

    localparam int unsigned WORD_W   = 32;
    localparam int unsigned ALU_OP_W = 4;

    localparam logic [ALU_OP_W-1:0] ALU_SLL  = 4'd0;
    localparam logic [ALU_OP_W-1:0] ALU_SRL  = 4'd1;
    localparam logic [ALU_OP_W-1:0] ALU_SRA  = 4'd2;
    localparam logic [ALU_OP_W-1:0] ALU_MUL  = 4'd3;
    localparam logic [ALU_OP_W-1:0] ALU_DIV  = 4'd4;
    localparam logic [ALU_OP_W-1:0] ALU_ADD  = 4'd5;
    localparam logic [ALU_OP_W-1:0] ALU_SUB  = 4'd6;
    localparam logic [ALU_OP_W-1:0] ALU_AND  = 4'd7;
    localparam logic [ALU_OP_W-1:0] ALU_OR   = 4'd8;
    localparam logic [ALU_OP_W-1:0] ALU_XOR  = 4'd9;
    localparam logic [ALU_OP_W-1:0] ALU_NOR  = 4'd10;
    localparam logic [ALU_OP_W-1:0] ALU_SLT  = 4'd11;
    localparam logic [ALU_OP_W-1:0] ALU_SLTU = 4'd12;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } hilo_state_t;

endpackage

// File: rtl/hilo_unit.sv
// MIPS HI/LO register pair with multi-cycle mult/div latency model and pipeline stall.
module hilo_unit
    import mips_pkg::*;
#(
    parameter int unsigned MULT_CYCLES = 4,
    parameter int unsigned DIV_CYCLES  = 12
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                issue,
    input  logic [ALU_OP_W-1:0] alu_op,
    input  logic [WORD_W-1:0]   alu_result,
    input  logic [WORD_W-1:0]   alu_result2,
    input  logic                mthi,
    input  logic                mtlo,
    input  logic [WORD_W-1:0]   wdata,
    input  logic                mfhi,
    input  logic                mflo,
    output logic [WORD_W-1:0]   rdata,
    output logic                busy,
    output logic                stall,
    output logic                done
);

    localparam int unsigned CNT_W = 8;

    hilo_state_t       state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [WORD_W-1:0] hi_q, hi_d, lo_q, lo_d;
    logic [WORD_W-1:0] pend_hi_q, pend_hi_d, pend_lo_q, pend_lo_d;
    logic              done_q, done_d;
    logic              muldiv_c;

    assign muldiv_c = issue && ((alu_op == ALU_MUL) || (alu_op == ALU_DIV));

    // State register and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            pend_hi_q <= '0;
            pend_lo_q <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            pend_hi_q <= pend_hi_d;
            pend_lo_q <= pend_lo_d;
            done_q    <= done_d;
        end
    end

    // Next-state: a start takes priority over MT writes in IDLE
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        pend_hi_d = pend_hi_q;
        pend_lo_d = pend_lo_q;
        done_d    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (muldiv_c) begin
                    state_d   = BUSY;
                    pend_lo_d = alu_result;
                    pend_hi_d = alu_result2;
                    cnt_d     = (alu_op == ALU_MUL) ? CNT_W'(MULT_CYCLES - 1)
                                                    : CNT_W'(DIV_CYCLES - 1);
                end else begin
                    if (mthi) hi_d = wdata;
                    if (mtlo) lo_d = wdata;
                end
            end
            BUSY: begin
                if (cnt_q == '0) begin
                    state_d = IDLE;
                    hi_d    = pend_hi_q;
                    lo_d    = pend_lo_q;
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy  = (state_q == BUSY);
    assign done  = done_q;
    assign stall = busy && (mfhi || mflo || mthi || mtlo || muldiv_c);
    assign rdata = mfhi ? hi_q : (mflo ? lo_q : '0);

endmodule

// File: tb/tb_hilo_unit.sv
// Directed bench for hilo_unit: timestamp-based reference model plus hand-computed checks.
module tb_hilo_unit;
    import mips_pkg::*;

    localparam int unsigned NM = 4;
    localparam int unsigned ND = 12;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        issue = 1'b0;
    logic [3:0]  alu_op = 4'd0;
    logic [31:0] alu_result = 32'd0;
    logic [31:0] alu_result2 = 32'd0;
    logic        mthi = 1'b0;
    logic        mtlo = 1'b0;
    logic [31:0] wdata = 32'd0;
    logic        mfhi = 1'b0;
    logic        mflo = 1'b0;
    logic [31:0] rdata;
    logic        busy;
    logic        stall;
    logic        done;

    hilo_unit #(.MULT_CYCLES(NM), .DIV_CYCLES(ND)) dut (
        .clk(clk), .rst_n(rst_n), .issue(issue), .alu_op(alu_op),
        .alu_result(alu_result), .alu_result2(alu_result2),
        .mthi(mthi), .mtlo(mtlo), .wdata(wdata), .mfhi(mfhi), .mflo(mflo),
        .rdata(rdata), .busy(busy), .stall(stall), .done(done)
    );

    always #5 clk = ~clk;

    int n_pass = 0;
    int n_total = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got %h, expected %h", name, act, exp);
        else n_pass++;
    endtask

    function automatic bit is_md(input logic [3:0] op);
        return (op == 4'd3) || (op == 4'd4);
    endfunction

    // Reference model: an operation started in cycle t occupies cycles t+1..t+N
    int          cyc = 0;
    bit          m_active = 1'b0;
    int          m_fin = 0;
    int          m_done_cyc = -1;
    logic [31:0] m_hi = 32'd0, m_lo = 32'd0, m_phi = 32'd0, m_plo = 32'd0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_active   <= 1'b0;
            m_done_cyc <= -1;
            m_hi <= 32'd0; m_lo <= 32'd0; m_phi <= 32'd0; m_plo <= 32'd0;
        end else begin
            if (m_active && cyc == m_fin) begin
                m_hi <= m_phi; m_lo <= m_plo;
                m_active   <= 1'b0;
                m_done_cyc <= cyc + 1;
            end else if (!m_active && issue && is_md(alu_op)) begin
                m_active <= 1'b1;
                m_fin    <= cyc + ((alu_op == 4'd3) ? int'(NM) : int'(ND));
                m_phi    <= alu_result2;
                m_plo    <= alu_result;
            end else if (!m_active) begin
                if (mthi) m_hi <= wdata;
                if (mtlo) m_lo <= wdata;
            end
            cyc <= cyc + 1;
        end
    end

    always @(negedge clk) begin
        chk("busy", 32'(busy), 32'(m_active));
        chk("done", 32'(done), 32'(cyc == m_done_cyc));
        chk("stall", 32'(stall),
            32'(m_active && (mfhi || mflo || mthi || mtlo || (issue && is_md(alu_op)))));
        chk("rdata", rdata, mfhi ? m_hi : (mflo ? m_lo : 32'd0));
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start_op(input logic [3:0] op, input logic [31:0] r, input logic [31:0] r2);
        alu_op = op; alu_result = r; alu_result2 = r2; issue = 1'b1;
        step();
        issue = 1'b0; alu_op = 4'd0;
    endtask

    task automatic wait_done(output int nb);
        bit got;
        got = 1'b0;
        nb = 0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (done) begin got = 1'b1; break; end
            if (busy) nb++;
        end
        chk("done_seen", 32'(got), 32'd1);
        #1;
    endtask

    task automatic read_hl(input string name, input logic [31:0] eh, input logic [31:0] el);
        mfhi = 1'b1; #1; chk({name, "_hi"}, rdata, eh);
        mflo = 1'b1; #1; chk({name, "_hi_wins"}, rdata, eh);
        mfhi = 1'b0; #1; chk({name, "_lo"}, rdata, el);
        mflo = 1'b0;
    endtask

    initial begin
        int nb;
        int nd;
        #1 rst_n = 1'b0;
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_stall", 32'(stall), 32'd0);
        mfhi = 1'b1; #1; chk("rst_rdata", rdata, 32'd0); mfhi = 1'b0;
        step(); step();
        rst_n = 1'b1;
        step();

        // 2*3
        start_op(4'd3, 32'd6, 32'd0);
        wait_done(nb);
        chk("mul_busy_cycles", 32'(nb), 32'd4);
        read_hl("mul", 32'h0000_0000, 32'h0000_0006);

        // 0x10000000 * 0x10000000, issued back-to-back in the done cycle
        start_op(4'd3, 32'h0000_0000, 32'h0100_0000);
        wait_done(nb);
        read_hl("wide", 32'h0100_0000, 32'h0000_0000);

        // 10/3 then 9/3
        start_op(4'd4, 32'd3, 32'd1);
        wait_done(nb);
        chk("div_busy_cycles", 32'(nb), 32'd12);
        read_hl("div10", 32'd1, 32'd3);
        start_op(4'd4, 32'd3, 32'd0);
        wait_done(nb);
        read_hl("div9", 32'd0, 32'd3);

        // mflo held from the 2nd busy cycle
        start_op(4'd3, 32'hAAAA_0001, 32'h0000_5555);
        step();
        mflo = 1'b1; #1;
        chk("stall_mflo", 32'(stall), 32'd1);
        wait_done(nb);
        chk("mflo_busy_left", 32'(nb), 32'd3);
        chk("mflo_after_done", rdata, 32'hAAAA_0001);
        mflo = 1'b0;

        // second multiply while busy must not restart the countdown
        start_op(4'd3, 32'h11, 32'h22);
        alu_op = 4'd3; alu_result = 32'd99; alu_result2 = 32'd98; issue = 1'b1;
        step();
        chk("stall_reissue", 32'(stall), 32'd1);
        step();
        issue = 1'b0; alu_op = 4'd0;
        wait_done(nb);
        chk("reissue_busy_left", 32'(nb), 32'd2);
        read_hl("reissue", 32'h22, 32'h11);

        // MTHI+MTLO together, then MTLO alone with same-cycle read of old value
        mthi = 1'b1; mtlo = 1'b1; wdata = 32'hDEAD_BEEF;
        step();
        mthi = 1'b0; mtlo = 1'b0;
        read_hl("mt_both", 32'hDEAD_BEEF, 32'hDEAD_BEEF);
        mtlo = 1'b1; wdata = 32'h1234_5678; mflo = 1'b1; #1;
        chk("mt_same_cycle_old", rdata, 32'hDEAD_BEEF);
        step();
        mtlo = 1'b0;
        chk("mt_lo_next", rdata, 32'h1234_5678);
        mflo = 1'b0;

        // start and MTHI in the same cycle: start wins
        mthi = 1'b1; wdata = 32'hCAFE_F00D;
        start_op(4'd3, 32'd7, 32'd8);
        mthi = 1'b0;
        wait_done(nb);
        read_hl("start_vs_mt", 32'd8, 32'd7);

        // reset in the 3rd divide cycle
        start_op(4'd4, 32'd5, 32'd6);
        step(); step();
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_done", 32'(done), 32'd0);
        read_hl("midrst", 32'd0, 32'd0);
        step();
        rst_n = 1'b1;
        nd = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (done) nd++;
        end
        chk("no_done_after_rst", 32'(nd), 32'd0);
        start_op(4'd3, 32'h0000_000F, 32'h0000_0000);
        wait_done(nb);
        chk("post_rst_busy_cycles", 32'(nb), 32'd4);
        read_hl("post_rst", 32'd0, 32'h0000_000F);

        step();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, passed %0d of %0d", n_pass, n_total);
        $fatal(1);
    end

endmodule
